// File: rtl/key_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_input_ctrl
// Brief    : Synchronises and debounces four push-buttons and turns presses
//            into move requests that stay pending until draw_finish.
// Options  : KEY_AUTOREPEAT_EN - auto-repeat for down/left/right while held
// Revision : 1.0 - initial release
// ============================================================================

module key_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 7500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CNT_W           = 24
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [3:0] key_sw,
  input  logic       draw_finish,
  output logic [3:0] op_keys,
  output logic [3:0] keys_held
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_HELD       = 2'd2,
    S_DB_RELEASE = 2'd3
  } key_state_t;

  localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] c_rep_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_rep_period_last = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Every terminal count must be reachable by a CNT_W-bit counter.
  if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) || (CNT_W < 1) ||
      (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(REPEAT_DELAY)    >= (64'd1 << CNT_W)) ||
      (64'(REPEAT_PERIOD)   >= (64'd1 << CNT_W))) begin : g_param_check
    $error("key_input_ctrl: counter parameters out of range for CNT_W");
  end

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_op_keys;
  logic [3:0] w_keys_held;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= key_sw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_held;
    logic             w_synced;
`ifdef KEY_AUTOREPEAT_EN
    // Rotate (bit 0) is deliberately excluded from auto-repeat.
    localparam bit c_rep = (i != 0);
    logic          r_rep_phase;
`endif

    assign w_synced = r_sync2[i];

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_op    <= 1'b0;
        r_held  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        r_rep_phase <= 1'b0;
`endif
      end else begin
        // Consume on draw_finish; an event raised below in the same cycle wins.
        r_op <= r_op & ~draw_finish;

        case (r_state)
          S_IDLE: begin
            r_held <= 1'b0;
            if (w_synced) begin
              r_state <= S_DB_PRESS;
              r_cnt   <= '0;
            end
          end

          S_DB_PRESS: begin
            if (!w_synced) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_db_last) begin
              r_state <= S_HELD;
              r_held  <= 1'b1;
              r_op    <= 1'b1;
              r_cnt   <= '0;
`ifdef KEY_AUTOREPEAT_EN
              r_rep_phase <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          S_HELD: begin
            if (!w_synced) begin
              r_state <= S_DB_RELEASE;
              r_cnt   <= '0;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (c_rep) begin
              // First repeat waits the long delay, later ones the short period.
              if ((!r_rep_phase && (r_cnt == c_rep_delay_last)) ||
                  ( r_rep_phase && (r_cnt == c_rep_period_last))) begin
                r_op        <= 1'b1;
                r_cnt       <= '0;
                r_rep_phase <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_cnt_one;
              end
            end
`endif
          end

          S_DB_RELEASE: begin
            if (w_synced) begin
              r_state <= S_HELD;
              r_cnt   <= '0;
            end else if (r_cnt == c_db_last) begin
              r_state <= S_IDLE;
              r_held  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
        endcase
      end
    end

    assign w_op_keys[i]   = r_op;
    assign w_keys_held[i] = r_held;
  end

  assign op_keys   = w_op_keys;
  assign keys_held = w_keys_held;

endmodule

`default_nettype wire

// File: tb/tb_key_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_input_ctrl
// Brief    : Self-checking bench for key_input_ctrl with short debounce and
//            repeat parameters; expected outputs queued per driven cycle.
// Revision : 1.0 - initial release
// ============================================================================

module tb_key_input_ctrl;

  localparam int c_debounce = 4;
  localparam int c_rep_delay = 20;
  localparam int c_rep_period = 8;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit c_autorep = 1'b1;
`else
  localparam bit c_autorep = 1'b0;
`endif

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_sw = 4'b0000;
  logic       draw_finish = 1'b0;
  logic [3:0] op_keys;
  logic [3:0] keys_held;

  key_input_ctrl #(
    .DEBOUNCE_CYCLES(c_debounce),
    .REPEAT_DELAY   (c_rep_delay),
    .REPEAT_PERIOD  (c_rep_period),
    .CNT_W          (24)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .key_sw     (key_sw),
    .draw_finish(draw_finish),
    .op_keys    (op_keys),
    .keys_held  (keys_held)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic       rst;
    logic [3:0] key;
    logic       df;
    int         len;
    logic [3:0] op;
    logic [3:0] held;
    string      name;
  } seg_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] held;
    string      name;
    int         cyc;
  } exp_t;

  seg_t segs[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add_seg(input logic r, input logic [3:0] k, input logic df, input int len,
                         input logic [3:0] eop, input logic [3:0] eheld, input string nm);
    seg_t s;
    s.rst = r; s.key = k; s.df = df; s.len = len; s.op = eop; s.held = eheld; s.name = nm;
    segs.push_back(s);
  endtask

  // Drive one cycle's inputs just after the edge and queue that cycle's expected outputs.
  task automatic drive(input logic r, input logic [3:0] k, input logic df,
                       input logic [3:0] eop, input logic [3:0] eheld, input string nm, input int cyc);
    exp_t e;
    @(posedge vga_clk);
    #1;
    reset = r;
    key_sw = k;
    draw_finish = df;
    e.op = eop; e.held = eheld; e.name = nm; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  always @(negedge vga_clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp += 2;
      if (op_keys !== e.op) begin
        n_bad++;
        $display("FAIL %s cyc %0d op_keys: actual=%b required=%b", e.name, e.cyc, op_keys, e.op);
      end
      if (keys_held !== e.held) begin
        n_bad++;
        $display("FAIL %s cyc %0d keys_held: actual=%b required=%b", e.name, e.cyc, keys_held, e.held);
      end
    end
  end

  function automatic bit is_event(input int bitn, input int c);
    if (c == 7) return 1'b1;
    if (c_autorep && (bitn != 0) && (c == 27 || c == 35 || c == 43)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    // Reset, single press with consume, release.
    add_seg(1, 4'b0000, 0, 3, 4'b0000, 4'b0000, "reset");
    add_seg(0, 4'b0000, 0, 2, 4'b0000, 4'b0000, "post_reset");
    add_seg(0, 4'b0010, 0, 7, 4'b0000, 4'b0000, "t1_debounce");
    add_seg(0, 4'b0010, 0, 3, 4'b0010, 4'b0010, "t1_press");
    add_seg(0, 4'b0010, 1, 1, 4'b0010, 4'b0010, "t1_df_cycle");
    add_seg(0, 4'b0010, 0, 4, 4'b0000, 4'b0010, "t1_consumed");
    add_seg(0, 4'b0000, 0, 7, 4'b0000, 4'b0010, "t1_release_db");
    add_seg(0, 4'b0000, 0, 4, 4'b0000, 4'b0000, "t1_idle");
    // Short glitches are rejected.
    add_seg(0, 4'b0100, 0, 3, 4'b0000, 4'b0000, "glitch3");
    add_seg(0, 4'b0000, 0, 10, 4'b0000, 4'b0000, "glitch3_idle");
    add_seg(0, 4'b1000, 0, 4, 4'b0000, 4'b0000, "glitch4");
    add_seg(0, 4'b0000, 0, 10, 4'b0000, 4'b0000, "glitch4_idle");
    // Shortest accepted pulse: press accepted, release debounced right after.
    add_seg(0, 4'b0001, 0, 5, 4'b0000, 4'b0000, "pulse5");
    add_seg(0, 4'b0000, 0, 2, 4'b0000, 4'b0000, "pulse5_wait");
    add_seg(0, 4'b0000, 0, 5, 4'b0001, 4'b0001, "pulse5_press");
    add_seg(0, 4'b0000, 0, 1, 4'b0001, 4'b0000, "pulse5_released");
    add_seg(0, 4'b0000, 1, 1, 4'b0001, 4'b0000, "pulse5_df");
    add_seg(0, 4'b0000, 0, 3, 4'b0000, 4'b0000, "pulse5_consumed");

    foreach (segs[s]) begin
      for (int c = 0; c < segs[s].len; c++) begin
        drive(segs[s].rst, segs[s].key, segs[s].df, segs[s].op, segs[s].held, segs[s].name, c);
      end
    end

    // Long hold with draw_finish every 4 cycles: right (bit 3) then rotate (bit 0).
    for (int k = 0; k < 2; k++) begin
      int         kb;
      logic [3:0] mask;
      kb = (k == 0) ? 3 : 0;
      mask = 4'(1) << kb;
      for (int c = 0; c < 60; c++) begin
        logic ev;
        ev = is_event(kb, c) || is_event(kb, c - 1);
        drive(0, (c < 46) ? mask : 4'b0000, (c % 4) == 0,
              ev ? mask : 4'b0000, (c >= 7 && c < 53) ? mask : 4'b0000,
              (k == 0) ? "hold_right" : "hold_rotate", c);
      end
    end

    // Event on bit 1 in the same cycle as draw_finish.
    for (int c = 0; c < 22; c++) begin
      drive(0, (c < 11) ? 4'b0010 : 4'b0000, (c == 6 || c == 9),
            (c >= 7 && c <= 9) ? 4'b0010 : 4'b0000,
            (c >= 7 && c < 18) ? 4'b0010 : 4'b0000, "event_vs_df", c);
    end

    // Reset with bit 1 pending and bit 2 mid-debounce, keys still held afterwards.
    for (int c = 0; c < 37; c++) begin
      logic [3:0] k;
      logic [3:0] eop;
      logic [3:0] eheld;
      k = (c < 8) ? 4'b0010 : ((c < 24) ? 4'b0110 : 4'b0000);
      if (c >= 7 && c <= 11)       eop = 4'b0010;
      else if (c >= 21 && c <= 32) eop = 4'b0110;
      else                         eop = 4'b0000;
      if (c >= 7 && c <= 11)       eheld = 4'b0010;
      else if (c >= 21 && c <= 30) eheld = 4'b0110;
      else                         eheld = 4'b0000;
      drive((c == 12 || c == 13), k, (c == 32), eop, eheld, "reset_mid", c);
    end

    repeat (3) @(negedge vga_clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: actual=%0d queued required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_input_ctrl.md
# key_input_ctrl

Key input conditioner sitting directly upstream of the grid/game controller. It synchronises and debounces the four raw push-buttons (up/rotate, down, left, right), turns each debounced press into a move request and optionally auto-repeats held movement keys. Each request is held as a pending flag on `op_keys` until the grid controller consumes it at the next `draw_finish` frame boundary.

## Interface
- `DEBOUNCE_CYCLES`, 250000: stable-input cycles needed to accept a level change (10 ms at 25 MHz).
- `REPEAT_DELAY`, 7500000: held cycles from accepted press to first auto-repeat (300 ms).
- `REPEAT_PERIOD`, 2500000: cycles between subsequent auto-repeats (100 ms).
- `CNT_W`, 24: width of every internal counter; all three parameters are below 2^CNT_W.
- `vga_clk`  in  1  25 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `key_sw`  in  4  raw buttons, active-high, asynchronous to `vga_clk`; bit 0 up, 1 down, 2 left, 3 right.
- `draw_finish`  in  1  frame-boundary strobe from the VGA controller; consume point for requests.
- `op_keys`  out  4  pending move requests, same bit order as `key_sw`.
- `keys_held`  out  4  debounced key levels.

## Operation
- Each bit passes through a 2-flop synchroniser. No logic reads an unsynchronised bit.
- Each key has its own FSM and CNT_W-bit counter:
  - IDLE: `keys_held`=0. Synced=1 → DB_PRESS, counter cleared.
  - DB_PRESS: counter increments while synced=1. Synced=0 → IDLE. Counter reaches DEBOUNCE_CYCLES-1 → HELD, raise a press event, counter cleared.
  - HELD: `keys_held`=1. Counter counts repeat time. Synced=0 → DB_RELEASE, counter cleared.
  - DB_RELEASE: synced=1 → HELD, and the repeat counter resumes from 0. Counter reaches DEBOUNCE_CYCLES-1 → IDLE.
- A press event sets `op_keys[i]`. `op_keys[i]` clears on any cycle with `draw_finish`=1. If an event and `draw_finish` occur in the same cycle, the event wins and the bit stays 1.
- Further events while `op_keys[i]` is already 1 are merged; there is no queueing and at most one request per key per frame.
- Keys are independent. Simultaneous left+right requests are both reported, and the grid controller arbitrates.
- Asserting `reset` mid-operation returns every FSM to IDLE, clears all counters and flags, and discards pending requests.

## Timing
- Reset values: `op_keys`=4'b0000, `keys_held`=4'b0000, synchronisers 0, all FSMs IDLE.
- Press latency: `key_sw[i]` rising to `op_keys[i]`=1 takes 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 registered-output cycle.
- `keys_held[i]` rises in the same cycle as `op_keys[i]`. It falls 2 + DEBOUNCE_CYCLES + 1 cycles after a clean release.
- `op_keys` falls in the cycle after the `draw_finish`-high cycle.
- Glitches shorter than DEBOUNCE_CYCLES produce no event and no `keys_held` change.
- Both outputs are registered, with no combinational path from an input.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: in HELD, bits 1–3 (down, left, right) raise an extra event when the counter reaches REPEAT_DELAY-1. After that, they raise one every REPEAT_PERIOD cycles, with the counter reloaded to 0 at each event. Bit 0 (rotate) never repeats.
- `KEY_AUTOREPEAT_EN` not defined: exactly one event per accepted press for all keys. The HELD counter logic is removed.

## Test plan
Test parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, `draw_finish` low unless stated.
- Reset, then apply `key_sw`=4'b0010 at cycle 0 and hold → `op_keys`=4'b0010 and `keys_held`=4'b0010 from cycle 7. Pulse `draw_finish` at cycle 10 → `op_keys`=0 at cycle 11.
- Pulse `key_sw[2]` high for 3 cycles → `op_keys` and `keys_held` stay 0.
- Hold `key_sw[3]` with `KEY_AUTOREPEAT_EN`, strobing `draw_finish` every 4 cycles → events at cycles 7, 27, 35, 43. Repeat with `key_sw[0]` → only the cycle-7 event.
- Same `key_sw[3]` hold without the macro → single event at cycle 7, then `op_keys` stays 0 after consumption.
- Event on bit 1 coinciding with the `draw_finish` cycle → `op_keys[1]` remains 1. The next `draw_finish` clears it.
- Assert `reset` while bit 2 is in DB_PRESS, release `reset` with the key still held → full debounce restarts and the event arrives 7 cycles after release.
